// File: rtl/shift_sweep_ctrl.sv
// Sweep controller for a pair of barrel shifters: latches an operand, steps the shift
// amount through every value with a fixed dwell, and publishes the captured results.
//
// state | meaning
// IDLE  | waiting for start; outputs hold their last captured values
// RUN   | dwelling on shift_out, capturing shifter results at the end of each dwell
// DONE  | single sweep finished; done is high for this one cycle
module shift_sweep_ctrl #(
    parameter int N           = 3,
    parameter int TICK_CYCLES = 50_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              loop_en,
    input  logic              abort,
    input  logic [2**N-1:0]   load_num,
    output logic [2**N-1:0]   num_out,
    output logic [N-1:0]      shift_out,
    input  logic [2**N-1:0]   result_left_in,
    input  logic [2**N-1:0]   result_right_in,
    output logic [2**N-1:0]   left_q,
    output logic [2**N-1:0]   right_q,
    output logic [N-1:0]      step_shift,
    output logic              step_valid,
    output logic              busy,
    output logic              done
);

    localparam int              CW        = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0]   CNT_LAST  = CW'(TICK_CYCLES - 1);
    localparam logic [N-1:0]    SHIFT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            loop_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            loop_q     <= 1'b0;
            num_out    <= '0;
            shift_out  <= '0;
            left_q     <= '0;
            right_q    <= '0;
            step_shift <= '0;
            step_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            step_valid <= 1'b0;
            done       <= 1'b0;
            case (state)
                IDLE: begin
                    // abort takes priority over a simultaneous start
                    if (start && !abort) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        num_out   <= load_num;
                        shift_out <= '0;
                        cnt       <= '0;
                        loop_q    <= loop_en;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        left_q     <= result_left_in;
                        right_q    <= result_right_in;
                        step_shift <= shift_out;
                        step_valid <= 1'b1;
                        cnt        <= '0;
                        if (shift_out != SHIFT_MAX) begin
                            shift_out <= shift_out + 1'b1;
                        end else if (loop_q) begin
                            shift_out <= '0;
                        end else begin
                            // shift_out deliberately holds at its maximum
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sweep_ctrl.sv
// Directed bench for shift_sweep_ctrl with N=3, TICK_CYCLES=4 and behavioural shifters.
module tb_shift_sweep_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       loop_en = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] load_num = 8'h00;
    logic [7:0] num_out;
    logic [2:0] shift_out;
    logic [7:0] result_left;
    logic [7:0] result_right;
    logic [7:0] left_q;
    logic [7:0] right_q;
    logic [2:0] step_shift;
    logic       step_valid;
    logic       busy;
    logic       done;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    assign result_left  = num_out << shift_out;
    assign result_right = num_out >> shift_out;

    shift_sweep_ctrl #(.N(3), .TICK_CYCLES(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .loop_en         (loop_en),
        .abort           (abort),
        .load_num        (load_num),
        .num_out         (num_out),
        .shift_out       (shift_out),
        .result_left_in  (result_left),
        .result_right_in (result_right),
        .left_q          (left_q),
        .right_q         (right_q),
        .step_shift      (step_shift),
        .step_valid      (step_valid),
        .busy            (busy),
        .done            (done)
    );

    typedef struct {
        logic [7:0] num;
        logic [2:0] shift;
        logic [7:0] left;
        logic [7:0] right;
        logic       done;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " num_out"}, num_out, 0);
        check({tag, " shift_out"}, shift_out, 0);
        check({tag, " left_q"}, left_q, 0);
        check({tag, " right_q"}, right_q, 0);
        check({tag, " step_shift"}, step_shift, 0);
        check({tag, " step_valid"}, step_valid, 0);
        check({tag, " busy"}, busy, 0);
        check({tag, " done"}, done, 0);
    endtask

    initial begin
        int k;
        logic       pulse_exp;
        logic [2:0] s;
        logic [7:0] e_left;
        logic [7:0] e_right;

        // hand-computed single sweep of 8'hD2
        tbl[0] = '{8'hD2, 3'd0, 8'hD2, 8'hD2, 1'b0};
        tbl[1] = '{8'hD2, 3'd1, 8'hA4, 8'h69, 1'b0};
        tbl[2] = '{8'hD2, 3'd2, 8'h48, 8'h34, 1'b0};
        tbl[3] = '{8'hD2, 3'd3, 8'h90, 8'h1A, 1'b0};
        tbl[4] = '{8'hD2, 3'd4, 8'h20, 8'h0D, 1'b0};
        tbl[5] = '{8'hD2, 3'd5, 8'h40, 8'h06, 1'b0};
        tbl[6] = '{8'hD2, 3'd6, 8'h80, 8'h03, 1'b0};
        tbl[7] = '{8'hD2, 3'd7, 8'h00, 8'h01, 1'b1};

        tick();
        tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();

        // single sweep, with an ignored start pulse mid-sweep
        load_num = tbl[0].num;
        loop_en  = 1'b0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        check("run busy", busy, 1);
        check("run num_out", num_out, 8'hD2);
        check("run shift_out", shift_out, 0);
        k = 0;
        for (int c = 1; c <= 33; c++) begin
            if (c == 2) begin
                start    = 1'b1;
                load_num = 8'h0F;
            end
            if (c == 3) start = 1'b0;
            tick();
            pulse_exp = (c % 4 == 0) && (c <= 32);
            check("single step_valid", step_valid, pulse_exp);
            check("single busy", busy, (c < 32));
            check("single num_out", num_out, 8'hD2);
            check("single shift_out", shift_out, (c >= 32) ? 7 : c / 4);
            if (pulse_exp) begin
                check("single step_shift", step_shift, tbl[k].shift);
                check("single left_q", left_q, tbl[k].left);
                check("single right_q", right_q, tbl[k].right);
                check("single done", done, tbl[k].done);
                k++;
            end else begin
                check("single done idle", done, 0);
            end
        end
        check("single pulse count", k, 8);

        // loop sweep of 8'hFF; abort on the edge that would capture step 2 of the second lap
        load_num = 8'hFF;
        loop_en  = 1'b1;
        start    = 1'b1;
        tick();
        start   = 1'b0;
        loop_en = 1'b0;
        for (int c = 1; c <= 44; c++) begin
            if (c == 44) abort = 1'b1;
            tick();
            if (c < 44) begin
                pulse_exp = (c % 4 == 0);
                check("loop step_valid", step_valid, pulse_exp);
                check("loop done", done, 0);
                check("loop busy", busy, 1);
                if (pulse_exp) begin
                    s       = 3'((c / 4 - 1) % 8);
                    e_left  = 8'hFF << s;
                    e_right = 8'hFF >> s;
                    check("loop step_shift", step_shift, s);
                    check("loop left_q", left_q, e_left);
                    check("loop right_q", right_q, e_right);
                end
            end else begin
                abort = 1'b0;
                check("abort step_valid", step_valid, 0);
                check("abort busy", busy, 0);
                check("abort done", done, 0);
                check("abort left_q", left_q, 8'hFE);
                check("abort right_q", right_q, 8'h7F);
                check("abort step_shift", step_shift, 1);
                check("abort shift_out", shift_out, 2);
            end
        end
        tick();
        check("abort stays idle", busy, 0);

        // abort beats start in IDLE, then start alone launches
        start    = 1'b1;
        abort    = 1'b1;
        load_num = 8'h3C;
        tick();
        check("abort+start busy", busy, 0);
        abort = 1'b0;
        tick();
        start = 1'b0;
        check("start after abort busy", busy, 1);
        check("start after abort num_out", num_out, 8'h3C);

        // asynchronous reset in the middle of a sweep
        for (int c = 0; c < 5; c++) tick();
        #2 reset = 1'b1;
        #1 check_all_zero("async reset");
        tick();
        reset = 1'b0;
        tick();
        tick();
        load_num = 8'h5A;
        start    = 1'b1;
        tick();
        start = 1'b0;
        check("restart busy", busy, 1);
        check("restart shift_out", shift_out, 0);
        tick();
        tick();
        tick();
        check("restart no early pulse", step_valid, 0);
        tick();
        check("restart step_valid", step_valid, 1);
        check("restart step_shift", step_shift, 0);
        check("restart left_q", left_q, 8'h5A);
        check("restart right_q", right_q, 8'h5A);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
